// File: rtl/alu_if_pkg.sv
// Shared definitions for the UART-driven ALU front end: FSM state encoding
// and the ALU opcode values used by the ALU, this interface and the benches.
package alu_if_pkg;

  localparam logic [2:0] ST_WAIT_A  = 3'd0;
  localparam logic [2:0] ST_WAIT_B  = 3'd1;
  localparam logic [2:0] ST_WAIT_OP = 3'd2;
  localparam logic [2:0] ST_CALC    = 3'd3;
  localparam logic [2:0] ST_SEND    = 3'd4;
  localparam logic [2:0] ST_WAIT_TX = 3'd5;

  typedef enum logic [2:0] {
    S_WAIT_A  = ST_WAIT_A,
    S_WAIT_B  = ST_WAIT_B,
    S_WAIT_OP = ST_WAIT_OP,
    S_CALC    = ST_CALC,
    S_SEND    = ST_SEND,
    S_WAIT_TX = ST_WAIT_TX
  } state_t;

  localparam logic [5:0] ADD = 6'd32;
  localparam logic [5:0] SUB = 6'd34;
  localparam logic [5:0] AND = 6'd36;
  localparam logic [5:0] OR  = 6'd37;
  localparam logic [5:0] XOR = 6'd38;
  localparam logic [5:0] SRA = 6'd3;
  localparam logic [5:0] SRL = 6'd2;
  localparam logic [5:0] NOR = 6'd39;

endpackage

// File: rtl/alu_if_watchdog.sv
// Inter-byte idle timer. Down-counter reloaded on every accepted byte;
// o_expire flags the cycle whose edge completes TIMEOUT_CYCLES-1 idle cycles.
module alu_if_watchdog #(
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  // Reload on a byte, otherwise count down while the FSM waits mid-frame.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      count <= LOAD;
    end else if (i_clear) begin
      count <= LOAD;
    end else if (i_enable && (count != '0)) begin
      count <= count - CW'(1);
    end
  end

  assign o_expire = i_enable && (count == CW'(1));

endmodule

// File: rtl/alu_uart_if.sv
// Frame responder between a UART rx/tx pair and the combinational ALU.
// Collects A, B, opcode bytes, holds them on the ALU inputs, registers the
// result and hands it to the transmitter with a start/done handshake.
// Optional inter-byte timeout enabled with macro ALU_IF_TIMEOUT_EN.
//
// state     | meaning
// WAIT_A    | idle, waiting for operand A byte
// WAIT_B    | waiting for operand B byte
// WAIT_OP   | waiting for opcode byte
// CALC      | ALU inputs stable, result registered this cycle
// SEND      | o_tx_start pulse
// WAIT_TX   | waiting for transmitter done
module alu_uart_if
  import alu_if_pkg::*;
#(
  parameter int NB_DATA        = 8,
  parameter int NB_OP          = 6,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_done,
  output logic               o_busy,
  output logic               o_timeout
);

  state_t state;
  logic   expire;

`ifdef ALU_IF_TIMEOUT_EN
  logic wd_clear;
  logic wd_enable;

  // Any accepted byte restarts the idle window; only mid-frame waits count.
  assign wd_clear  = i_rx_done && ((state == S_WAIT_A) || (state == S_WAIT_B) ||
                                   (state == S_WAIT_OP));
  assign wd_enable = !i_rx_done && ((state == S_WAIT_B) || (state == S_WAIT_OP));

  alu_if_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_clear (wd_clear),
    .i_enable(wd_enable),
    .o_expire(expire)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign expire = 1'b0;
`endif

  // Frame sequencing FSM with registered operand, result and handshake outputs.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state      <= S_WAIT_A;
      o_alu_a    <= '0;
      o_alu_b    <= '0;
      o_alu_op   <= '0;
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
      o_busy     <= 1'b0;
      o_timeout  <= 1'b0;
    end else begin
      o_tx_start <= 1'b0;
      o_timeout  <= 1'b0;
      case (state)
        S_WAIT_A: begin
          if (i_rx_done) begin
            o_alu_a <= i_rx_data;
            state   <= S_WAIT_B;
          end
        end
        S_WAIT_B: begin
          // A byte in the expiry cycle wins over the timeout.
          if (i_rx_done) begin
            o_alu_b <= i_rx_data;
            state   <= S_WAIT_OP;
          end else if (expire) begin
            o_timeout <= 1'b1;
            state     <= S_WAIT_A;
          end
        end
        S_WAIT_OP: begin
          if (i_rx_done) begin
            o_alu_op <= i_rx_data[NB_OP-1:0];
            o_busy   <= 1'b1;
            state    <= S_CALC;
          end else if (expire) begin
            o_timeout <= 1'b1;
            state     <= S_WAIT_A;
          end
        end
        S_CALC: begin
          o_tx_data  <= i_alu_result;
          o_tx_start <= 1'b1;
          state      <= S_SEND;
        end
        S_SEND: begin
          state <= S_WAIT_TX;
        end
        S_WAIT_TX: begin
          if (i_tx_done) begin
            o_busy <= 1'b0;
            state  <= S_WAIT_A;
          end
        end
        default: begin
          o_busy <= 1'b0;
          state  <= S_WAIT_A;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_uart_if.sv
// Self-checking bench for alu_uart_if: table-driven frames with a result
// scoreboard, plus hand sequences for discard, collision, reset and timeout.
module tb_alu_uart_if;
  import alu_if_pkg::*;

  localparam int NB_DATA = 8;
  localparam int NB_OP   = 6;
  localparam int TO      = 16;

  logic               i_clock = 1'b0;
  logic               i_reset = 1'b0;
  logic [NB_DATA-1:0] i_rx_data = '0;
  logic               i_rx_done = 1'b0;
  logic               i_tx_done = 1'b0;
  logic [NB_DATA-1:0] i_alu_result;
  logic [NB_DATA-1:0] o_alu_a, o_alu_b, o_tx_data;
  logic [NB_OP-1:0]   o_alu_op;
  logic               o_tx_start, o_busy, o_timeout;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] sb[$];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] opb;
    logic [5:0] op;
    logic [7:0] res;
  } vec_t;

  vec_t vecs[9];

  alu_uart_if #(
    .NB_DATA(NB_DATA),
    .NB_OP(NB_OP),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_rx_data   (i_rx_data),
    .i_rx_done   (i_rx_done),
    .o_alu_a     (o_alu_a),
    .o_alu_b     (o_alu_b),
    .o_alu_op    (o_alu_op),
    .i_alu_result(i_alu_result),
    .o_tx_data   (o_tx_data),
    .o_tx_start  (o_tx_start),
    .i_tx_done   (i_tx_done),
    .o_busy      (o_busy),
    .o_timeout   (o_timeout)
  );

  always #5 i_clock = ~i_clock;

  // Reference ALU driving the result input from the registered operands.
  always_comb begin
    i_alu_result = '0;
    case (o_alu_op)
      ADD: i_alu_result = o_alu_a + o_alu_b;
      SUB: i_alu_result = o_alu_a - o_alu_b;
      AND: i_alu_result = o_alu_a & o_alu_b;
      OR:  i_alu_result = o_alu_a | o_alu_b;
      XOR: i_alu_result = o_alu_a ^ o_alu_b;
      SRA: i_alu_result = $signed(o_alu_a) >>> o_alu_b;
      SRL: i_alu_result = o_alu_a >> o_alu_b;
      NOR: i_alu_result = ~(o_alu_a | o_alu_b);
      default: i_alu_result = '0;
    endcase
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  // Scoreboard: every start pulse must carry the next expected result.
  always @(negedge i_clock) begin
    if (i_reset && o_tx_start) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL tx_unexpected: got start with data 0x%02h expected none", o_tx_data);
      end else begin
        logic [7:0] e;
        e = sb.pop_front();
        if (o_tx_data !== e) begin
          n_fail++;
          $display("FAIL tx_data: got 0x%02h expected 0x%02h", o_tx_data, e);
        end
      end
    end
  end

  task automatic rx_byte(input logic [7:0] b);
    @(negedge i_clock);
    i_rx_data = b;
    i_rx_done = 1'b1;
    @(negedge i_clock);
    i_rx_done = 1'b0;
  endtask

  task automatic tx_done_pulse();
    @(negedge i_clock);
    i_tx_done = 1'b1;
    @(negedge i_clock);
    i_tx_done = 1'b0;
  endtask

  task automatic run_frame(input vec_t v, input bit finish_tx);
    rx_byte(v.a);
    rx_byte(v.b);
    sb.push_back(v.res);
    rx_byte(v.opb);
    check("alu_a", o_alu_a, v.a);
    check("alu_b", o_alu_b, v.b);
    check("alu_op", {2'b00, o_alu_op}, {2'b00, v.op});
    check("busy_calc", {7'd0, o_busy}, 8'd1);
    check("start_early", {7'd0, o_tx_start}, 8'd0);
    @(negedge i_clock);
    check("start_latency", {7'd0, o_tx_start}, 8'd1);
    @(negedge i_clock);
    check("start_width", {7'd0, o_tx_start}, 8'd0);
    check("busy_wait_tx", {7'd0, o_busy}, 8'd1);
    if (finish_tx) begin
      tx_done_pulse();
      check("busy_after_done", {7'd0, o_busy}, 8'd0);
    end
  endtask

  initial begin
    int pulses;
    int at;
    vecs[0] = '{8'h05, 8'h03, 8'h20, ADD, 8'h08};
    vecs[1] = '{8'h03, 8'h05, 8'h22, SUB, 8'hFE};
    vecs[2] = '{8'h03, 8'h05, 8'hE2, SUB, 8'hFE};
    vecs[3] = '{8'h01, 8'h01, 8'h25, OR,  8'h01};
    vecs[4] = '{8'hF0, 8'h0F, 8'h26, XOR, 8'hFF};
    vecs[5] = '{8'h80, 8'h01, 8'h03, SRA, 8'hC0};
    vecs[6] = '{8'h80, 8'h02, 8'h02, SRL, 8'h20};
    vecs[7] = '{8'h0F, 8'hF0, 8'h27, NOR, 8'h00};
    vecs[8] = '{8'hFF, 8'h0F, 8'hE4, AND, 8'h0F};

    repeat (3) @(negedge i_clock);
    check("rst_alu_a", o_alu_a, 8'h00);
    check("rst_alu_b", o_alu_b, 8'h00);
    check("rst_alu_op", {2'b00, o_alu_op}, 8'h00);
    check("rst_tx_data", o_tx_data, 8'h00);
    check("rst_tx_start", {7'd0, o_tx_start}, 8'd0);
    check("rst_busy", {7'd0, o_busy}, 8'd0);
    check("rst_timeout", {7'd0, o_timeout}, 8'd0);
    i_reset = 1'b1;

    for (int i = 0; i < 9; i++) run_frame(vecs[i], 1'b1);

    // Byte during WAIT_TX is discarded, next frame runs normally.
    run_frame('{8'h01, 8'h02, 8'h20, ADD, 8'h03}, 1'b0);
    rx_byte(8'h7F);
    check("discard_alu_a", o_alu_a, 8'h01);
    check("discard_busy", {7'd0, o_busy}, 8'd1);
    tx_done_pulse();
    check("discard_done_busy", {7'd0, o_busy}, 8'd0);
    run_frame('{8'h01, 8'h01, 8'h25, OR, 8'h01}, 1'b1);

    // rx_done and tx_done together in WAIT_TX.
    run_frame('{8'h0A, 8'h0B, 8'h20, ADD, 8'h15}, 1'b0);
    @(negedge i_clock);
    i_rx_data = 8'h5A;
    i_rx_done = 1'b1;
    i_tx_done = 1'b1;
    @(negedge i_clock);
    i_rx_done = 1'b0;
    i_tx_done = 1'b0;
    check("collide_busy", {7'd0, o_busy}, 8'd0);
    check("collide_alu_a", o_alu_a, 8'h0A);
    run_frame('{8'h21, 8'h02, 8'h22, SUB, 8'h1F}, 1'b1);

    // Reset after two bytes of a frame.
    rx_byte(8'h11);
    rx_byte(8'h22);
    check("mid_alu_a", o_alu_a, 8'h11);
    check("mid_alu_b", o_alu_b, 8'h22);
    @(negedge i_clock);
    i_reset = 1'b0;
    #1;
    check("mrst_alu_a", o_alu_a, 8'h00);
    check("mrst_alu_b", o_alu_b, 8'h00);
    check("mrst_alu_op", {2'b00, o_alu_op}, 8'h00);
    check("mrst_tx_data", o_tx_data, 8'h00);
    check("mrst_busy", {7'd0, o_busy}, 8'd0);
    check("mrst_tx_start", {7'd0, o_tx_start}, 8'd0);
    check("mrst_timeout", {7'd0, o_timeout}, 8'd0);
    @(negedge i_clock);
    i_reset = 1'b1;
    run_frame('{8'h07, 8'h06, 8'h20, ADD, 8'h0D}, 1'b1);

    // One byte then idle.
    rx_byte(8'h33);
    pulses = 0;
    at = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge i_clock);
      if (o_timeout) begin
        pulses++;
        at = k;
      end
    end
`ifdef ALU_IF_TIMEOUT_EN
    check("timeout_pulses", 8'(pulses), 8'd1);
    check("timeout_cycle", 8'(at), 8'd15);
    run_frame('{8'h44, 8'h01, 8'h20, ADD, 8'h45}, 1'b1);
`else
    check("no_timeout_pulses", 8'(pulses), 8'd0);
    check("no_timeout_cycle", 8'(at), 8'd0);
    rx_byte(8'h44);
    sb.push_back(8'h77);
    rx_byte(8'h20);
    check("wait_b_alu_a", o_alu_a, 8'h33);
    check("wait_b_alu_b", o_alu_b, 8'h44);
    @(negedge i_clock);
    check("wait_b_start", {7'd0, o_tx_start}, 8'd1);
    @(negedge i_clock);
    tx_done_pulse();
    check("wait_b_busy", {7'd0, o_busy}, 8'd0);
`endif

    repeat (2) @(negedge i_clock);
    check("sb_empty", 8'(sb.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_uart_if.md
# alu_uart_if

Frame-level responder between a UART receiver/transmitter pair and the combinational ALU. It collects three consecutive received bytes as operand A, operand B and opcode, and holds them on the ALU inputs. It then registers the ALU result and hands it to the UART transmitter with a start/done handshake. It replaces the button/switch loading path of the ALU top when the design is driven over a serial link.

## Interface
- NB_DATA, 8, operand/result/byte width
- NB_OP, 6, opcode width; taken from the low bits of the third byte
- TIMEOUT_CYCLES, 50000000, inter-byte idle limit; used only with ALU_IF_TIMEOUT_EN

- i_clock  in  1  system clock, rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_rx_data  in  NB_DATA  received byte, valid when i_rx_done=1
- i_rx_done  in  1  one-cycle pulse per received byte
- o_alu_a  out  NB_DATA  registered operand A
- o_alu_b  out  NB_DATA  registered operand B
- o_alu_op  out  NB_OP  registered opcode
- i_alu_result  in  NB_DATA  combinational ALU result
- o_tx_data  out  NB_DATA  registered result byte for the transmitter
- o_tx_start  out  1  one-cycle pulse requesting transmission of o_tx_data
- i_tx_done  in  1  one-cycle pulse when the transmitter finishes the byte
- o_busy  out  1  high in CALC, SEND and WAIT_TX
- o_timeout  out  1  one-cycle pulse when a partial frame is aborted

## Operation
- FSM states: WAIT_A, WAIT_B, WAIT_OP, CALC, SEND, WAIT_TX. Reset state is WAIT_A.
- WAIT_A: on i_rx_done, capture i_rx_data into o_alu_a and go to WAIT_B.
- WAIT_B: on i_rx_done, capture i_rx_data into o_alu_b and go to WAIT_OP.
- WAIT_OP: on i_rx_done, capture i_rx_data[NB_OP-1:0] into o_alu_op and go to CALC. The upper byte bits are ignored.
- CALC: register i_alu_result into o_tx_data and go to SEND.
- SEND: assert o_tx_start for exactly this cycle, then go to WAIT_TX.
- WAIT_TX: on i_tx_done, go to WAIT_A. Otherwise stay in WAIT_TX.
- i_rx_done while o_busy=1: the byte is discarded and no register changes.
- i_tx_done outside WAIT_TX is ignored.
- i_rx_done and i_tx_done in the same WAIT_TX cycle: go to WAIT_A and discard the byte.
- Operand and opcode registers hold their values until overwritten by the next frame. The ALU inputs are therefore stable through CALC/SEND/WAIT_TX.
- No arithmetic in this block. The result is passed through at NB_DATA width, unmodified.

## Timing
- Reset values: o_alu_a=0, o_alu_b=0, o_alu_op=0, o_tx_data=0, o_tx_start=0, o_busy=0, o_timeout=0.
- Reset assertion at any point, including mid-frame or in WAIT_TX, returns the FSM to WAIT_A immediately. A partial frame is lost.
- Byte capture happens on the edge where i_rx_done=1.
- Opcode captured at edge N, CALC in cycle N..N+1, result registered at edge N+1, o_tx_start high in cycle N+1..N+2. Latency is 2 clocks from opcode byte to start pulse.
- o_busy rises together with entry into CALC. It falls on the edge that accepts i_tx_done.
- The earliest next-frame byte is accepted the cycle after returning to WAIT_A.

## Configuration
- ALU_IF_TIMEOUT_EN defined:
  - An idle counter clears at every accepted byte and counts each cycle in WAIT_B and WAIT_OP.
  - When it reaches TIMEOUT_CYCLES-1 with no byte, the FSM goes to WAIT_A and pulses o_timeout for one cycle.
  - Operand registers are not cleared.
  - A byte arriving in the same cycle as expiry wins: it is captured and there is no timeout.
- ALU_IF_TIMEOUT_EN undefined:
  - No counter is built and o_timeout is tied to 0.
  - WAIT_B and WAIT_OP wait indefinitely.
  - TIMEOUT_CYCLES is unused.

## Structure
- Shared package alu_if_pkg holds:
  - the state encoding localparams;
  - the opcode constants ADD=32, SUB=34, AND=36, OR=37, XOR=38, SRA=3, SRL=2, NOR=39, also used by the ALU and the benches.
- One sub-module, alu_if_watchdog: the idle counter with clear/enable/expire signals. It is instantiated only under ALU_IF_TIMEOUT_EN.

## Test plan
- Send rx bytes 0x05, 0x03, 0x20 with the ALU model returning 8'h08:
  - o_alu_a=0x05, o_alu_b=0x03, o_alu_op=32;
  - o_tx_data=0x08 with o_tx_start high exactly 2 cycles after the third i_rx_done;
  - after i_tx_done, o_busy=0.
- Send bytes 0x03, 0x05, 0x22 (SUB) with the model result 0xFE: o_tx_data=0xFE. Also send third byte 0xE2: o_alu_op=34, upper bits dropped.
- Send byte 0x7F during WAIT_TX: o_alu_a remains unchanged. A following full frame 0x01, 0x01, 0x25 is processed normally.
- Pulse i_rx_done and i_tx_done together in WAIT_TX: the FSM returns to WAIT_A and the byte is not captured in o_alu_a.
- Assert i_reset=0 after two bytes of a frame: all outputs return to 0 immediately. After release, a fresh 3-byte frame completes.
- With ALU_IF_TIMEOUT_EN and TIMEOUT_CYCLES=16:
  - send one byte, then idle: o_timeout pulses once, 15 cycles after the byte, and the FSM is in WAIT_A;
  - without the macro, the same stimulus leaves the FSM in WAIT_B.
